// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned TO_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_wb;
        logic redirect_if;
    } ctrl_t;

    // Whole pipeline frozen with a bubble going into WB
    localparam ctrl_t CTRL_HOLD = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
                                    stall_mem: 1'b1, flush_id: 1'b0, flush_ex: 1'b0,
                                    flush_wb: 1'b1, redirect_if: 1'b0};

    localparam ctrl_t CTRL_RESET = '{stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0,
                                     stall_mem: 1'b0, flush_id: 1'b1, flush_ex: 1'b1,
                                     flush_wb: 1'b1, redirect_if: 1'b0};

    // Front-end hazards once the data side is not blocking: branch > load-use > fetch wait
    function automatic ctrl_t run_ctrl(input logic branch, input logic load_use,
                                       input logic imem_ready);
        ctrl_t c;
        c = '0;
        if (branch) begin
            c.redirect_if = 1'b1;
            c.flush_id    = 1'b1;
            c.flush_ex    = 1'b1;
        end else if (load_use) begin
            c.stall_if = 1'b1;
            c.stall_id = 1'b1;
            c.flush_ex = 1'b1;
        end else if (!imem_ready) begin
            c.stall_if = 1'b1;
            c.flush_id = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush/counter outputs of the pipeline sequencer.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             load_use_EX;
    logic             branch_taken_EX;
    logic             dmem_req_MEM;
    logic             dmem_ready;
    logic             imem_ready;
    logic             halt_WB;
    logic             stall_IF;
    logic             stall_ID;
    logic             stall_EX;
    logic             stall_MEM;
    logic             flush_ID;
    logic             flush_EX;
    logic             flush_WB;
    logic             redirect_IF;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output load_use_EX, branch_taken_EX, dmem_req_MEM, dmem_ready, imem_ready, halt_WB,
        input  stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_WB,
        input  redirect_IF, halted, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use_EX, branch_taken_EX, dmem_req_MEM, dmem_ready, imem_ready, halt_WB,
        output stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_WB,
        output redirect_IF, halted, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Enable-driven wrap-around event counter with synchronous reset.
module pipe_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazards, memory waits
// and halt into per-stage controls; tracks data-wait timeout and perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            to_q, to_d;
    ctrl_t           ctrl_c;
    logic            halted_c;
    logic            dmiss_c;

    assign dmiss_c = bus.dmem_req_MEM & ~bus.dmem_ready;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        to_d     = to_q;
        ctrl_c   = '0;
        halted_c = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmiss_c) begin
                    ctrl_c  = CTRL_HOLD;
                    wait_d  = TO_W'(1);
                    state_d = ST_DWAIT;
                end else begin
                    ctrl_c = run_ctrl(bus.branch_taken_EX, bus.load_use_EX, bus.imem_ready);
                end
                if (bus.halt_WB) state_d = ST_HALT;
            end
            ST_DWAIT: begin
                if (!bus.dmem_ready) begin
                    ctrl_c = CTRL_HOLD;
                    if (wait_q == TO_W'(TIMEOUT)) begin
                        to_d    = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end else begin
                    ctrl_c  = run_ctrl(bus.branch_taken_EX, bus.load_use_EX, bus.imem_ready);
                    state_d = ST_RUN;
                end
                // Halt retiring abandons the outstanding access
                if (bus.halt_WB) state_d = ST_HALT;
            end
            ST_HALT: begin
                ctrl_c   = CTRL_HOLD;
                halted_c = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            ctrl_c   = CTRL_RESET;
            halted_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
        end
    end

    pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ctrl_c.stall_if & (state_q != ST_HALT)),
        .cnt_o (bus.stall_cnt)
    );

    pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ctrl_c.redirect_if),
        .cnt_o (bus.flush_cnt)
    );

    assign bus.stall_IF    = ctrl_c.stall_if;
    assign bus.stall_ID    = ctrl_c.stall_id;
    assign bus.stall_EX    = ctrl_c.stall_ex;
    assign bus.stall_MEM   = ctrl_c.stall_mem;
    assign bus.flush_ID    = ctrl_c.flush_id;
    assign bus.flush_EX    = ctrl_c.flush_ex;
    assign bus.flush_WB    = ctrl_c.flush_wb;
    assign bus.redirect_IF = ctrl_c.redirect_if;
    assign bus.halted      = halted_c;
    assign bus.mem_timeout = to_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (TIMEOUT reduced to 4).
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int unsigned CNT_W = 32;

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        ctrl_t            ctrl;
        logic             halted;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    function automatic ctrl_t mk(input logic sif, sid, sex, smem, fid, fex, fwb, rif);
        ctrl_t c;
        c = '{stall_if: sif, stall_id: sid, stall_ex: sex, stall_mem: smem,
              flush_id: fid, flush_ex: fex, flush_wb: fwb, redirect_if: rif};
        return c;
    endfunction

    ctrl_t C_NONE, C_RST, C_LU, C_BR, C_IW, C_DW;
    initial begin
        C_NONE = mk(0, 0, 0, 0, 0, 0, 0, 0);
        C_RST  = mk(0, 0, 0, 0, 1, 1, 1, 0);
        C_LU   = mk(1, 1, 0, 0, 0, 1, 0, 0);
        C_BR   = mk(0, 0, 0, 0, 1, 1, 0, 1);
        C_IW   = mk(1, 0, 0, 0, 1, 0, 0, 0);
        C_DW   = mk(1, 1, 1, 1, 0, 0, 1, 0);
    end

    // Drive one cycle of inputs and queue what the DUT must show during it
    task automatic step(input string tag, input logic chk,
                        input logic r, lu, br, dreq, drdy, irdy, hlt,
                        input ctrl_t ec, input logic eh, input logic eto);
        exp_t e;
        @(negedge clk);
        rst                 = r;
        bus.load_use_EX     = lu;
        bus.branch_taken_EX = br;
        bus.dmem_req_MEM    = dreq;
        bus.dmem_ready      = drdy;
        bus.imem_ready      = irdy;
        bus.halt_WB         = hlt;
        if (chk) begin
            e.tag = tag; e.ctrl = ec; e.halted = eh; e.to = eto;
            e.sc = m_stall; e.fc = m_flush;
            q.push_back(e);
        end
        if (r) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (ec.stall_if && !eh) m_stall = m_stall + CNT_W'(1);
            if (ec.redirect_if)     m_flush = m_flush + CNT_W'(1);
        end
    endtask

    // Monitor: samples mid-low-phase, after inputs settle
    initial begin : monitor
        exp_t  e;
        ctrl_t act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = mk(bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.stall_MEM,
                         bus.flush_ID, bus.flush_EX, bus.flush_WB, bus.redirect_IF);
                n_checks += 5;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL %s ctrl: got %b expected %b", e.tag, act, e.ctrl);
                end
                if (bus.halted !== e.halted) begin
                    n_fail++;
                    $display("FAIL %s halted: got %b expected %b", e.tag, bus.halted, e.halted);
                end
                if (bus.mem_timeout !== e.to) begin
                    n_fail++;
                    $display("FAIL %s mem_timeout: got %b expected %b", e.tag, bus.mem_timeout, e.to);
                end
                if (bus.stall_cnt !== e.sc) begin
                    n_fail++;
                    $display("FAIL %s stall_cnt: got %0d expected %0d", e.tag, bus.stall_cnt, e.sc);
                end
                if (bus.flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL %s flush_cnt: got %0d expected %0d", e.tag, bus.flush_cnt, e.fc);
                end
            end
        end
    end

    initial begin : stim
        //   tag          chk r lu br dq dr ir ht  exp     hlt to
        step("prereset",  0, 1, 0, 0, 0, 0, 1, 0, C_RST,  0, 0);
        step("reset",     1, 1, 0, 0, 0, 0, 1, 0, C_RST,  0, 0);
        step("idle0",     1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
        step("lu",        1, 0, 1, 0, 0, 0, 1, 0, C_LU,   0, 0);
        step("lu_after",  1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
        step("br_lu",     1, 0, 1, 1, 0, 0, 1, 0, C_BR,   0, 0);
        step("br_after",  1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
        step("iw_lu",     1, 0, 1, 0, 0, 0, 0, 0, C_LU,   0, 0);
        step("iw",        1, 0, 0, 0, 0, 0, 0, 0, C_IW,   0, 0);
        step("br_iw",     1, 0, 0, 1, 0, 0, 0, 0, C_BR,   0, 0);
        step("dw_enter",  1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("dw_1",      1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("dw_2",      1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("dw_ready",  1, 0, 0, 0, 1, 1, 1, 0, C_NONE, 0, 0);
        step("dw_idle",   1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
        step("dw2_enter", 1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("dw2_rdylu", 1, 0, 1, 0, 1, 1, 1, 0, C_LU,   0, 0);
        step("to_enter",  1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("to_w1",     1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("to_w2",     1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("to_w3",     1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("to_w4",     1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("to_halt",   1, 0, 0, 0, 0, 0, 1, 0, C_DW,   1, 1);
        step("to_hbr",    1, 0, 0, 1, 0, 1, 1, 0, C_DW,   1, 1);
        step("to_rst",    1, 1, 0, 0, 0, 0, 1, 0, C_RST,  0, 1);
        step("to_clear",  1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
        step("halt_lu",   1, 0, 1, 0, 0, 0, 1, 1, C_LU,   0, 0);
        step("halt_1",    1, 0, 0, 0, 0, 0, 1, 0, C_DW,   1, 0);
        step("halt_2",    1, 0, 1, 0, 0, 0, 0, 0, C_DW,   1, 0);
        step("halt_rst",  1, 1, 0, 0, 0, 0, 1, 0, C_RST,  0, 0);
        step("halt_clr",  1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
        step("dwh_enter", 1, 0, 0, 0, 1, 0, 1, 0, C_DW,   0, 0);
        step("dwh_halt",  1, 0, 0, 0, 1, 0, 1, 1, C_DW,   0, 0);
        step("dwh_held",  1, 0, 0, 0, 0, 0, 1, 0, C_DW,   1, 0);
        step("dwh_rst",   1, 1, 0, 0, 0, 0, 1, 0, C_RST,  0, 0);
        step("dhit",      1, 0, 0, 0, 1, 1, 1, 0, C_NONE, 0, 0);
        step("miss_halt", 1, 0, 0, 0, 1, 0, 1, 1, C_DW,   0, 0);
        step("mh_held",   1, 0, 0, 0, 0, 0, 1, 0, C_DW,   1, 0);
        step("mh_rst",    1, 1, 0, 0, 0, 0, 1, 0, C_RST,  0, 0);
        step("final",     1, 0, 0, 0, 0, 0, 1, 0, C_NONE, 0, 0);

        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
